// File: rtl/sonic_pkg.sv
// Shared types and constants for the ultrasonic distance filter.
package sonic_pkg;

  // Tracking state of the filter.
  typedef enum logic [1:0] {
    FILL  = 2'b00,
    TRACK = 2'b01,
    LOST  = 2'b10
  } state_t;

  localparam int DIST_W = 20;
  localparam int SUM_W  = 11;

  localparam int DEF_SAMPLE_PERIOD = 5_000_000;
  localparam int DEF_MAX_CM        = 400;
  localparam int DEF_MISS_LIMIT    = 3;
  localparam int DEF_NEAR_CM       = 20;
  localparam int DEF_FAR_CM        = 30;

  // A reading is usable when it is non-zero and no larger than max_cm.
  function automatic logic dist_in_range(input logic [DIST_W-1:0] d,
                                         input int unsigned       max_cm);
    return (d != {DIST_W{1'b0}}) && (d <= DIST_W'(max_cm));
  endfunction

endpackage

// File: rtl/sonic_filter_if.sv
// Sensor-to-consumer bundle: raw distance in, filtered results out.
interface sonic_filter_if;
  import sonic_pkg::*;

  logic [DIST_W-1:0] distance;
  logic [DIST_W-1:0] dist_avg;
  logic              dist_valid;
  logic              new_sample;
  logic              near;

  // Side that supplies distance and consumes the filtered outputs.
  modport master (
    output distance,
    input  dist_avg,
    input  dist_valid,
    input  new_sample,
    input  near
  );

  // The filter itself.
  modport slave (
    input  distance,
    output dist_avg,
    output dist_valid,
    output new_sample,
    output near
  );

endinterface

// File: rtl/sonic_window.sv
// Four-entry circular window of accepted readings with a running sum.
// clr together with wr_en restarts the window with din as entry 0.
module sonic_window
  import sonic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              clr,
  input  logic [SUM_W-1:0]  din,
  output logic [DIST_W-1:0] avg,
  output logic [DIST_W-1:0] avg_next
);

  logic [SUM_W-1:0] mem_r [4];
  logic [SUM_W-1:0] sum_r;
  logic [1:0]       wp_r;
  logic [SUM_W-1:0] sum_next_s;

  // Running sum after this cycle's write or clear; modular arithmetic is exact
  // because the true sum of four in-range readings always fits.
  always_comb begin
    sum_next_s = sum_r;
    if (clr) begin
      if (wr_en) begin
        sum_next_s = din;
      end else begin
        sum_next_s = {SUM_W{1'b0}};
      end
    end else if (wr_en) begin
      sum_next_s = sum_r - mem_r[wp_r] + din;
    end else begin
      sum_next_s = sum_r;
    end
  end

  assign avg      = {{(DIST_W - SUM_W + 2){1'b0}}, sum_r[SUM_W-1:2]};
  assign avg_next = {{(DIST_W - SUM_W + 2){1'b0}}, sum_next_s[SUM_W-1:2]};

  // Buffer, write pointer and sum storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mem_r[i] <= {SUM_W{1'b0}};
      end
      wp_r  <= 2'd0;
      sum_r <= {SUM_W{1'b0}};
    end else begin
      sum_r <= sum_next_s;
      if (clr) begin
        for (int i = 0; i < 4; i++) begin
          mem_r[i] <= {SUM_W{1'b0}};
        end
        if (wr_en) begin
          mem_r[0] <= din;
          wp_r     <= 2'd1;
        end else begin
          wp_r     <= 2'd0;
        end
      end else if (wr_en) begin
        mem_r[wp_r] <= din;
        wp_r        <= wp_r + 2'd1;
      end else begin
        wp_r <= wp_r;
      end
    end
  end

endmodule

// File: rtl/sonic_filter.sv
// Ultrasonic distance post-processing: periodic sampling, stability and
// range checks, 4-reading moving average and a hysteretic obstacle flag.
module sonic_filter
  import sonic_pkg::*;
#(
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
  parameter int MAX_CM        = DEF_MAX_CM,
  parameter int MISS_LIMIT    = DEF_MISS_LIMIT,
  parameter int NEAR_CM       = DEF_NEAR_CM,
  parameter int FAR_CM        = DEF_FAR_CM
) (
  input logic           clk,
  input logic           rst,
  sonic_filter_if.slave sif
);

  localparam int TMR_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SAMPLE_PERIOD - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);
  localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(MISS_LIMIT);
  localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);

  logic [DIST_W-1:0] d1_r;
  logic [DIST_W-1:0] d2_r;
  logic [TMR_W-1:0]  timer_r;
  logic              pending_r;
  state_t            state_r;
  state_t            state_nxt_s;
  logic [1:0]        fill_r;
  logic [1:0]        fill_nxt_s;
  logic [MISS_W-1:0] miss_r;
  logic [MISS_W-1:0] miss_nxt_s;
  logic [DIST_W-1:0] dist_avg_r;
  logic              dist_valid_r;
  logic              new_sample_r;
  logic              near_r;
  logic              near_nxt_s;

  logic              stable_s;
  logic              tick_s;
  logic              accept_s;
  logic              rd_ok_s;
  logic              win_wr_s;
  logic              win_clr_s;
  logic              upd_s;
  logic [DIST_W-1:0] win_avg_s;
  logic [DIST_W-1:0] win_avg_next_s;

  assign stable_s = (d1_r == d2_r);
  assign tick_s   = (timer_r == TMR_LAST);
  assign accept_s = pending_r & stable_s;
  assign rd_ok_s  = dist_in_range(d2_r, MAX_CM);

  sonic_window u_window (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (win_wr_s),
    .clr      (win_clr_s),
    .din      (d2_r[SUM_W-1:0]),
    .avg      (win_avg_s),
    .avg_next (win_avg_next_s)
  );

  // Double-register the asynchronous distance and run the sample timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1_r      <= {DIST_W{1'b0}};
      d2_r      <= {DIST_W{1'b0}};
      timer_r   <= {TMR_W{1'b0}};
      pending_r <= 1'b0;
    end else begin
      d1_r <= sif.distance;
      d2_r <= d1_r;
      if (tick_s) begin
        timer_r <= {TMR_W{1'b0}};
      end else begin
        timer_r <= timer_r + TMR_W'(1);
      end
      // An accept consumes the request; a tick while already pending is absorbed.
      if (accept_s) begin
        pending_r <= 1'b0;
      end else if (tick_s) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  // Next state, counters and window control for each accepted reading.
  always_comb begin
    state_nxt_s = state_r;
    fill_nxt_s  = fill_r;
    miss_nxt_s  = miss_r;
    win_wr_s    = 1'b0;
    win_clr_s   = 1'b0;
    upd_s       = 1'b0;
    case (state_r)
      FILL: begin
        if (accept_s && rd_ok_s) begin
          win_wr_s   = 1'b1;
          miss_nxt_s = {MISS_W{1'b0}};
          if (fill_r == 2'd3) begin
            state_nxt_s = TRACK;
            fill_nxt_s  = 2'd0;
            upd_s       = 1'b1;
          end else begin
            fill_nxt_s = fill_r + 2'd1;
          end
        end else if (accept_s) begin
          if (miss_r >= MISS_LAST) begin
            state_nxt_s = LOST;
            miss_nxt_s  = MISS_MAX;
          end else begin
            miss_nxt_s = miss_r + MISS_ONE;
          end
        end else begin
          state_nxt_s = FILL;
        end
      end
      TRACK: begin
        if (accept_s && rd_ok_s) begin
          win_wr_s   = 1'b1;
          miss_nxt_s = {MISS_W{1'b0}};
          upd_s      = 1'b1;
        end else if (accept_s) begin
          if (miss_r >= MISS_LAST) begin
            state_nxt_s = LOST;
            miss_nxt_s  = MISS_MAX;
          end else begin
            miss_nxt_s = miss_r + MISS_ONE;
          end
        end else begin
          state_nxt_s = TRACK;
        end
      end
      LOST: begin
        if (accept_s && rd_ok_s) begin
          // Restart the window with this reading as its first entry.
          win_wr_s    = 1'b1;
          win_clr_s   = 1'b1;
          fill_nxt_s  = 2'd1;
          miss_nxt_s  = {MISS_W{1'b0}};
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = LOST;
        end
      end
      default: begin
        state_nxt_s = FILL;
        fill_nxt_s  = 2'd0;
        miss_nxt_s  = {MISS_W{1'b0}};
        win_clr_s   = 1'b1;
      end
    endcase
  end

  // Obstacle hysteresis; while tracking the window average equals dist_avg,
  // since every window write in TRACK also updates the output register.
  always_comb begin
    near_nxt_s = 1'b0;
    if (state_r == TRACK) begin
      if (win_avg_s < DIST_W'(NEAR_CM)) begin
        near_nxt_s = 1'b1;
      end else if (win_avg_s >= DIST_W'(FAR_CM)) begin
        near_nxt_s = 1'b0;
      end else begin
        near_nxt_s = near_r;
      end
    end else begin
      near_nxt_s = 1'b0;
    end
  end

  // State register and per-accept counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FILL;
      fill_r  <= 2'd0;
      miss_r  <= {MISS_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      fill_r  <= fill_nxt_s;
      miss_r  <= miss_nxt_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      dist_avg_r   <= {DIST_W{1'b0}};
      dist_valid_r <= 1'b0;
      new_sample_r <= 1'b0;
      near_r       <= 1'b0;
    end else begin
      if (upd_s) begin
        dist_avg_r <= win_avg_next_s;
      end else begin
        dist_avg_r <= dist_avg_r;
      end
      dist_valid_r <= (state_nxt_s == TRACK);
      new_sample_r <= upd_s;
      near_r       <= near_nxt_s;
    end
  end

  assign sif.dist_avg   = dist_avg_r;
  assign sif.dist_valid = dist_valid_r;
  assign sif.new_sample = new_sample_r;
  assign sif.near       = near_r;

endmodule

// File: tb/tb_sonic_filter.sv
// Self-checking bench for sonic_filter with a short sample period.
module tb_sonic_filter;

  localparam int PERIOD = 100;

  logic clk;
  logic rst;

  sonic_filter_if sif ();

  sonic_filter #(
    .SAMPLE_PERIOD (PERIOD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pos    = 0;  // clock edges since the last reset edge
  int k      = 0;  // index of the latest scheduled sample request

  // Reference model: history of good readings since the last (re)start.
  int hist[$];
  bit m_track;
  bit m_lost;
  int m_miss;
  int m_avg;
  bit m_near;
  bit m_ns;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    m_track = 1'b0;
    m_lost  = 1'b0;
    m_miss  = 0;
    m_avg   = 0;
    m_near  = 1'b0;
    m_ns    = 1'b0;
  endfunction

  function automatic void model_accept(input int v);
    int s;
    m_ns = 1'b0;
    if (v >= 1 && v <= 400) begin
      if (m_lost) begin
        hist.delete();
        m_lost = 1'b0;
      end
      hist.push_back(v);
      if (hist.size() > 4) void'(hist.pop_front());
      m_miss = 0;
      if (hist.size() == 4) m_track = 1'b1;
      if (m_track) begin
        s = 0;
        foreach (hist[i]) s += hist[i];
        m_avg = s / 4;
        m_ns  = 1'b1;
      end
    end else if (!m_lost) begin
      m_miss++;
      if (m_miss >= 3) begin
        m_lost  = 1'b1;
        m_track = 1'b0;
      end
    end
    if (m_track) begin
      if (m_avg < 20) m_near = 1'b1;
      else if (m_avg >= 30) m_near = 1'b0;
    end else begin
      m_near = 1'b0;
    end
  endfunction

  // Advance to the falling edge that follows rising edge number t.
  task automatic goto(input int t);
    while (pos < t) begin
      @(posedge clk);
      pos++;
    end
    @(negedge clk);
  endtask

  task automatic check_accept(input string tag);
    chk({tag, "_avg"}, 32'(sif.dist_avg), 32'(m_avg));
    chk({tag, "_valid"}, 32'(sif.dist_valid), 32'(m_track));
    chk({tag, "_ns"}, 32'(sif.new_sample), 32'(m_ns));
  endtask

  task automatic check_after(input string tag);
    chk({tag, "_near"}, 32'(sif.near), 32'(m_near));
    chk({tag, "_ns_low"}, 32'(sif.new_sample), 32'd0);
  endtask

  // One clean sample: value held well before and through the accept.
  task automatic sample(input string tag, input int v);
    k++;
    goto(PERIOD * k - 50);
    sif.distance = v[19:0];
    goto(PERIOD * k + 1);
    model_accept(v);
    check_accept(tag);
    goto(PERIOD * k + 2);
    check_after(tag);
  endtask

  // Distance toggles 60/61 across a tick, then settles on 61.
  task automatic unstable();
    int t0;
    int h;
    k++;
    t0 = PERIOD * k - 10;
    h  = PERIOD * k + 5;
    goto(t0);
    sif.distance = 20'd60;
    for (int j = 1; j <= h - t0; j++) begin
      goto(t0 + j);
      sif.distance = (j % 2 == 1) ? 20'd61 : 20'd60;
      if (t0 + j >= PERIOD * k + 1) chk("toggle_no_accept", 32'(sif.new_sample), 32'd0);
    end
    goto(h + 1);
    chk("hold1_no_accept", 32'(sif.new_sample), 32'd0);
    goto(h + 2);
    chk("hold2_no_accept", 32'(sif.new_sample), 32'd0);
    goto(h + 3);
    model_accept(61);
    check_accept("stable61");
    goto(h + 4);
    check_after("stable61");
  endtask

  initial begin
    int r;
    int v;
    model_reset();
    sif.distance = 20'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pos = 0;
    chk("rst_avg", 32'(sif.dist_avg), 32'd0);
    chk("rst_valid", 32'(sif.dist_valid), 32'd0);
    chk("rst_ns", 32'(sif.new_sample), 32'd0);
    chk("rst_near", 32'(sif.near), 32'd0);

    // Fill with a constant reading.
    for (int i = 0; i < 4; i++) sample("fill", 100);

    // Averaging and truncation.
    sample("avg_a", 100); sample("avg_a", 100); sample("avg_a", 100); sample("avg_a", 104);
    chk("avg_101", 32'(sif.dist_avg), 32'd101);
    sample("avg_b", 10); sample("avg_b", 11); sample("avg_b", 11); sample("avg_b", 11);
    chk("avg_10", 32'(sif.dist_avg), 32'd10);

    // Hysteresis steps.
    for (int i = 0; i < 4; i++) sample("hys40", 40);
    for (int i = 0; i < 4; i++) sample("hys19", 19);
    chk("near_at_19", 32'(sif.near), 32'd1);
    for (int i = 0; i < 4; i++) sample("hys25", 25);
    chk("near_at_25", 32'(sif.near), 32'd1);
    for (int i = 0; i < 4; i++) sample("hys30", 30);
    chk("near_at_30", 32'(sif.near), 32'd0);

    // Dropout and refill.
    for (int i = 0; i < 3; i++) sample("drop", 0);
    chk("drop_avg_held", 32'(sif.dist_avg), 32'd30);
    sample("refill_first", 50);
    for (int i = 0; i < 3; i++) sample("refill", 50);
    chk("refill_valid", 32'(sif.dist_valid), 32'd1);

    // Unstable input across a tick.
    unstable();

    // Reset pulse on the cycle of a pending accept.
    k++;
    goto(PERIOD * k - 50);
    sif.distance = 20'd200;
    goto(PERIOD * k);
    rst = 1'b1;
    goto(PERIOD * k + 1);
    rst = 1'b0;
    pos = 0;
    k   = 0;
    model_reset();
    chk("mid_rst_avg", 32'(sif.dist_avg), 32'd0);
    chk("mid_rst_valid", 32'(sif.dist_valid), 32'd0);
    chk("mid_rst_ns", 32'(sif.new_sample), 32'd0);
    chk("mid_rst_near", 32'(sif.near), 32'd0);
    goto(1);
    chk("mid_rst_ns_next", 32'(sif.new_sample), 32'd0);
    for (int i = 0; i < 4; i++) sample("post_rst_fill", 200);

    // Range boundaries.
    sample("max_ok", 400);
    sample("over_max", 401);
    sample("min_ok", 1);

    // Randomized readings, biased toward the hysteresis band.
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(99, 0));
      if (r < 12) v = 0;
      else if (r < 24) v = int'($urandom_range(1048575, 401));
      else if (r < 60) v = int'($urandom_range(45, 5));
      else v = int'($urandom_range(400, 1));
      sample("rand", v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
